// File: rtl/h264_vlc_packer.sv
// H.264 VLC bit packer: gathers variable-length codewords MSB-first into a
// 40-bit accumulator, emits bytes with emulation-prevention insertion, and
// terminates a NAL with an RBSP stop bit plus byte-alignment padding.
module h264_vlc_packer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VALID,
  input  logic [19:0] VE,
  input  logic [4:0]  VL,
  input  logic        FLUSH,
  output logic        READY,
  output logic [7:0]  BYTE,
  output logic        STROBE,
  output logic        DONE
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [39:0] acc_q, acc_d;
  logic [5:0]  fill_q, fill_d;
  logic [1:0]  zc_q, zc_d;
  logic [7:0]  byte_q, byte_d;
  logic        strobe_q, strobe_d;
  logic        done_q, done_d;

  logic        emitDue;
  logic        epb;
  logic [4:0]  vlEff;
  logic [39:0] codeMasked;
  logic [39:0] accS;
  logic [5:0]  fillS;
  logic [3:0]  padLen;

  // Input is only taken while running with room for a worst-case codeword
  assign READY  = (state_q == RUN) && (fill_q <= 6'd20);
  assign BYTE   = byte_q;
  assign STROBE = strobe_q;
  assign DONE   = done_q;

  // Next-state: emit (or insert 0x03) first, then append codeword and flush padding
  always_comb begin
    state_d    = state_q;
    zc_d       = zc_q;
    byte_d     = byte_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    emitDue    = (fill_q >= 6'd8);
    epb        = emitDue && (zc_q == 2'd2) && (acc_q[39:34] == 6'd0);
    vlEff      = (VL > 5'd20) ? 5'd20 : VL;
    codeMasked = {20'd0, VE} & ((40'd1 << vlEff) - 40'd1);
    accS       = acc_q;
    fillS      = fill_q;
    padLen     = 4'd0;

    if (emitDue) begin
      strobe_d = 1'b1;
      if (epb) begin
        byte_d = 8'h03;
        zc_d   = 2'd0;
      end else begin
        byte_d = acc_q[39:32];
        accS   = acc_q << 8;
        fillS  = fill_q - 6'd8;
        if (acc_q[39:32] == 8'h00)
          zc_d = (zc_q == 2'd2) ? 2'd2 : zc_q + 2'd1;
        else
          zc_d = 2'd0;
      end
    end

    if (VALID && READY) begin
      accS  = accS | (codeMasked << (6'd40 - fillS - {1'b0, vlEff}));
      fillS = fillS + {1'b0, vlEff};
    end

    if (FLUSH && READY) begin
      padLen  = 4'd8 - {1'b0, fillS[2:0]};
      accS    = accS | (40'h80_0000_0000 >> fillS);
      fillS   = fillS + {2'b00, padLen};
      state_d = DRAIN;
    end

    if ((state_q == DRAIN) && (fillS == 6'd0)) begin
      done_d  = 1'b1;
      state_d = RUN;
      zc_d    = 2'd0;
    end

    acc_d  = accS;
    fill_d = fillS;
  end

  // State register; reset discards every buffered bit immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= RUN;
      acc_q    <= 40'd0;
      fill_q   <= 6'd0;
      zc_q     <= 2'd0;
      byte_q   <= 8'h00;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      zc_q     <= zc_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_h264_vlc_packer.sv
// Self-checking bench for h264_vlc_packer using a bit-queue reference model.
module tb_h264_vlc_packer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        VALID;
  logic [19:0] VE;
  logic [4:0]  VL;
  logic        FLUSH;
  logic        READY;
  logic [7:0]  BYTE;
  logic        STROBE;
  logic        DONE;

  int errors = 0;
  int checks = 0;

  // Reference model state: pending bits in order, zero-byte run, drain flag
  bit         mq[$];
  int         mzc;
  bit         mdrain;
  logic [7:0] expByte;
  bit         expStrobe;
  bit         expDone;
  bit         expReadyPre;
  logic       obsReadyPre;
  bit         lastAccepted;

  h264_vlc_packer dut (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .VE(VE), .VL(VL), .FLUSH(FLUSH),
    .READY(READY), .BYTE(BYTE), .STROBE(STROBE), .DONE(DONE)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic model_reset();
    mq.delete();
    mzc       = 0;
    mdrain    = 0;
    expByte   = 8'h00;
    expStrobe = 0;
    expDone   = 0;
  endtask

  // Drive one cycle of inputs, advance to just after the edge, update model
  task automatic cycle(input bit v, input logic [19:0] ve, input logic [4:0] vl, input bit fl);
    int n;
    int val;
    VALID = v; VE = ve; VL = vl; FLUSH = fl;
    expReadyPre = !mdrain && (mq.size() <= 20);
    obsReadyPre = READY;
    @(posedge CLK);
    #1;
    expStrobe = 0;
    expDone   = 0;
    if (mq.size() >= 8) begin
      val = 0;
      for (int i = 0; i < 8; i++) val = val * 2 + int'(mq[i]);
      expStrobe = 1;
      if (mzc == 2 && val < 4) begin
        expByte = 8'h03;
        mzc = 0;
      end else begin
        expByte = val[7:0];
        repeat (8) void'(mq.pop_front());
        mzc = (val == 0) ? ((mzc < 2) ? mzc + 1 : 2) : 0;
      end
    end
    lastAccepted = expReadyPre && v;
    if (lastAccepted) begin
      n = (vl > 20) ? 20 : int'(vl);
      for (int i = n - 1; i >= 0; i--) mq.push_back(ve[i]);
    end
    if (expReadyPre && fl) begin
      mq.push_back(1'b1);
      while (mq.size() % 8 != 0) mq.push_back(1'b0);
      mdrain = 1;
    end
    if (mdrain && mq.size() == 0) begin
      expDone = 1;
      mdrain  = 0;
      mzc     = 0;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; VALID = 0; VE = '0; VL = '0; FLUSH = 0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RESET = 1'b1; VALID = 0; VE = '0; VL = '0; FLUSH = 0;
    #1;
    checks += 4;
    if (READY !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", READY); end
    if (STROBE !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b expected 0", STROBE); end
    if (BYTE !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte: got %h expected 00", BYTE); end
    if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", DONE); end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic test_ones();
    int strobes = 0;
    for (int c = 0; c < 11; c++) begin
      cycle(c < 8, 20'h1, 5'd1, 0);
      checks += 4;
      if (obsReadyPre !== expReadyPre) begin errors++; $display("[TB] FAIL ones_ready c%0d: got %b expected %b", c, obsReadyPre, expReadyPre); end
      if (STROBE !== expStrobe) begin errors++; $display("[TB] FAIL ones_strobe c%0d: got %b expected %b", c, STROBE, expStrobe); end
      if (BYTE !== expByte) begin errors++; $display("[TB] FAIL ones_byte c%0d: got %h expected %h", c, BYTE, expByte); end
      if (DONE !== expDone) begin errors++; $display("[TB] FAIL ones_done c%0d: got %b expected %b", c, DONE, expDone); end
      if (STROBE === 1'b1) begin
        strobes++;
        checks++;
        if (BYTE !== 8'hFF) begin errors++; $display("[TB] FAIL ones_value: got %h expected ff", BYTE); end
      end
    end
    checks++;
    if (strobes != 1) begin errors++; $display("[TB] FAIL ones_count: got %0d strobes expected 1", strobes); end
    // With nothing buffered a flush yields a bare 0x80 stop byte
    cycle(0, 20'h0, 5'd0, 1);
    cycle(0, 20'h0, 5'd0, 0);
    checks += 2;
    if (STROBE !== 1'b1 || BYTE !== 8'h80) begin errors++; $display("[TB] FAIL ones_empty_flush: got strobe=%b byte=%h expected 1 80", STROBE, BYTE); end
    if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL ones_empty_done: got %b expected 1", DONE); end
  endtask

  task automatic test_two_codes();
    logic [19:0] ves[4] = '{20'h2, 20'h1F, 20'h0, 20'h0};
    logic [4:0]  vls[4] = '{5'd3, 5'd5, 5'd0, 5'd0};
    bit          vs[4]  = '{1, 1, 0, 0};
    for (int c = 0; c < 4; c++) begin
      cycle(vs[c], ves[c], vls[c], 0);
      checks += 4;
      if (obsReadyPre !== expReadyPre) begin errors++; $display("[TB] FAIL two_ready c%0d: got %b expected %b", c, obsReadyPre, expReadyPre); end
      if (STROBE !== expStrobe) begin errors++; $display("[TB] FAIL two_strobe c%0d: got %b expected %b", c, STROBE, expStrobe); end
      if (BYTE !== expByte) begin errors++; $display("[TB] FAIL two_byte c%0d: got %h expected %h", c, BYTE, expByte); end
      if (DONE !== expDone) begin errors++; $display("[TB] FAIL two_done c%0d: got %b expected %b", c, DONE, expDone); end
      if (c == 1) begin
        checks++;
        if (STROBE !== 1'b0) begin errors++; $display("[TB] FAIL two_early: got strobe %b expected 0", STROBE); end
      end
      if (c == 2) begin
        checks++;
        if (STROBE !== 1'b1 || BYTE !== 8'h5F) begin errors++; $display("[TB] FAIL two_latency: got strobe=%b byte=%h expected 1 5f", STROBE, BYTE); end
      end
    end
  endtask

  task automatic test_emulation();
    logic [19:0] ves[7] = '{20'h0, 20'h01, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
    logic [4:0]  vls[7] = '{5'd16, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    bit          vs[7]  = '{1, 1, 0, 0, 0, 0, 0};
    logic [7:0]  want[4] = '{8'h00, 8'h00, 8'h03, 8'h01};
    logic [7:0]  got[$];
    int          firstStrobe = -1;
    for (int c = 0; c < 7; c++) begin
      cycle(vs[c], ves[c], vls[c], 0);
      checks += 4;
      if (obsReadyPre !== expReadyPre) begin errors++; $display("[TB] FAIL epb_ready c%0d: got %b expected %b", c, obsReadyPre, expReadyPre); end
      if (STROBE !== expStrobe) begin errors++; $display("[TB] FAIL epb_strobe c%0d: got %b expected %b", c, STROBE, expStrobe); end
      if (BYTE !== expByte) begin errors++; $display("[TB] FAIL epb_byte c%0d: got %h expected %h", c, BYTE, expByte); end
      if (DONE !== expDone) begin errors++; $display("[TB] FAIL epb_done c%0d: got %b expected %b", c, DONE, expDone); end
      if (STROBE === 1'b1) begin
        if (firstStrobe < 0) firstStrobe = c;
        checks++;
        if (c - firstStrobe != got.size()) begin errors++; $display("[TB] FAIL epb_consecutive: gap at cycle %0d", c); end
        got.push_back(BYTE);
      end
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("[TB] FAIL epb_count: got %0d bytes expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== want[i]) begin errors++; $display("[TB] FAIL epb_seq[%0d]: got %h expected %h", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit          sent[$];
    logic [7:0]  got[$];
    int          stalls = 0;
    logic [19:0] ve;
    int          nb;
    logic [7:0]  wantB;
    for (int c = 0; c < 30; c++) begin
      ve = 20'($urandom) | 20'h80200;
      cycle(c < 20, ve, 5'd20, 0);
      if (lastAccepted) for (int i = 19; i >= 0; i--) sent.push_back(ve[i]);
      if (obsReadyPre === 1'b0) stalls++;
      checks += 4;
      if (obsReadyPre !== expReadyPre) begin errors++; $display("[TB] FAIL bp_ready c%0d: got %b expected %b", c, obsReadyPre, expReadyPre); end
      if (STROBE !== expStrobe) begin errors++; $display("[TB] FAIL bp_strobe c%0d: got %b expected %b", c, STROBE, expStrobe); end
      if (BYTE !== expByte) begin errors++; $display("[TB] FAIL bp_byte c%0d: got %h expected %h", c, BYTE, expByte); end
      if (DONE !== expDone) begin errors++; $display("[TB] FAIL bp_done c%0d: got %b expected %b", c, DONE, expDone); end
      if (STROBE === 1'b1) got.push_back(BYTE);
    end
    checks++;
    if (stalls == 0) begin errors++; $display("[TB] FAIL bp_stall: got 0 stall cycles expected >0"); end
    nb = sent.size() / 8;
    checks++;
    if (got.size() != nb) begin errors++; $display("[TB] FAIL bp_bytes: got %0d bytes expected %0d", got.size(), nb); end
    for (int b = 0; b < nb && b < got.size(); b++) begin
      for (int i = 0; i < 8; i++) wantB[7-i] = sent[b*8+i];
      checks++;
      if (got[b] !== wantB) begin errors++; $display("[TB] FAIL bp_stream[%0d]: got %h expected %h", b, got[b], wantB); end
    end
  endtask

  task automatic test_flush();
    cycle(1, 20'h5, 5'd3, 1);
    checks += 2;
    if (STROBE !== 1'b0) begin errors++; $display("[TB] FAIL flush_early: got strobe %b expected 0", STROBE); end
    if (READY !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready_drain: got %b expected 0", READY); end
    cycle(1, 20'h7, 5'd3, 0);
    checks += 4;
    if (STROBE !== 1'b1 || BYTE !== 8'hB0) begin errors++; $display("[TB] FAIL flush_byte: got strobe=%b byte=%h expected 1 b0", STROBE, BYTE); end
    if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL flush_done: got %b expected 1", DONE); end
    if (READY !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_after: got %b expected 1", READY); end
    if (obsReadyPre !== 1'b0) begin errors++; $display("[TB] FAIL flush_ignored_valid: got ready %b expected 0", obsReadyPre); end
    cycle(0, 20'h0, 5'd0, 0);
    checks += 2;
    if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL flush_done_pulse: got %b expected 0", DONE); end
    if (STROBE !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_extra: got %b expected 0", STROBE); end
  endtask

  task automatic test_reset_drain();
    cycle(1, 20'($urandom) | 20'h80000, 5'd20, 1);
    cycle(0, 20'h0, 5'd0, 0);
    checks++;
    if (STROBE !== 1'b1) begin errors++; $display("[TB] FAIL rd_setup: got strobe %b expected 1", STROBE); end
    RESET = 1'b1;
    #1;
    checks += 3;
    if (STROBE !== 1'b0) begin errors++; $display("[TB] FAIL rd_strobe: got %b expected 0", STROBE); end
    if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL rd_done: got %b expected 0", DONE); end
    if (READY !== 1'b1) begin errors++; $display("[TB] FAIL rd_ready: got %b expected 1", READY); end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(0, 20'h0, 5'd0, 0);
      checks += 2;
      if (STROBE !== 1'b0) begin errors++; $display("[TB] FAIL rd_quiet c%0d: got strobe %b expected 0", c, STROBE); end
      if (DONE !== 1'b0) begin errors++; $display("[TB] FAIL rd_quiet_done c%0d: got %b expected 0", c, DONE); end
    end
  endtask

  task automatic test_random();
    bit          v, fl;
    logic [19:0] ve;
    logic [4:0]  vl;
    int          guard;
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      vl = 5'($urandom_range(0, 31));
      ve = ($urandom_range(0, 2) == 0) ? 20'h0 : 20'($urandom);
      fl = ($urandom_range(0, 29) == 0);
      cycle(v, ve, vl, fl);
      checks += 4;
      if (obsReadyPre !== expReadyPre) begin errors++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", c, obsReadyPre, expReadyPre); end
      if (STROBE !== expStrobe) begin errors++; $display("[TB] FAIL rnd_strobe c%0d: got %b expected %b", c, STROBE, expStrobe); end
      if (BYTE !== expByte) begin errors++; $display("[TB] FAIL rnd_byte c%0d: got %h expected %h", c, BYTE, expByte); end
      if (DONE !== expDone) begin errors++; $display("[TB] FAIL rnd_done c%0d: got %b expected %b", c, DONE, expDone); end
    end
    guard = 0;
    while (!mdrain && guard < 10) begin
      cycle(0, 20'h0, 5'd0, 1);
      guard++;
    end
    guard = 0;
    while (mdrain && guard < 20) begin
      cycle(0, 20'h0, 5'd0, 0);
      guard++;
      checks += 2;
      if (STROBE !== expStrobe) begin errors++; $display("[TB] FAIL rnd_drain_strobe: got %b expected %b", STROBE, expStrobe); end
      if (DONE !== expDone) begin errors++; $display("[TB] FAIL rnd_drain_done: got %b expected %b", DONE, expDone); end
    end
    checks++;
    if (mdrain) begin errors++; $display("[TB] FAIL rnd_drain_bound: drain did not finish within 20 cycles"); end
  endtask

  // Test sequence
  initial begin
    VALID = 0; VE = '0; VL = '0; FLUSH = 0; RESET = 1'b1;
    model_reset();
    test_reset();
    test_ones();
    do_reset();
    test_two_codes();
    do_reset();
    test_emulation();
    do_reset();
    test_backpressure();
    do_reset();
    test_flush();
    do_reset();
    test_reset_drain();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
